// File: rtl/flag_cdc_pkg.sv
// Shared types and constants for the flag_cdc feeder path.
// min_gap() gives the pulse spacing that flag_cdc can resolve for a given pair of clock periods.
package flag_cdc_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, SPACE} state_e;

  localparam int DEF_GAP = 6;

  // flag_cdc needs about three clkB periods (two sync flops and the edge detect) per event.
  // One extra clkA cycle is added as margin, and the result is never below 2.
  function automatic int min_gap(input int period_a, input int period_b);
    int cycles;
    cycles = (3 * period_b + period_a - 1) / period_a + 1;
    return (cycles < 2) ? 2 : cycles;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down event counter. An increment while full with no decrement is reported as a drop.
// A simultaneous inc and dec leaves the count unchanged.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: defaults first so every path assigns count_d and drop; otherwise a latch is inferred.
    count_d = count_q;
    drop    = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) drop = 1'b1;
      else                count_d = count_q + W'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == MAX);

endmodule

// File: rtl/flag_pacer.sv
// Paces queued event strobes onto A as single-cycle pulses whose rising edges are at least GAP cycles apart.
// This lets flag_cdc see every accepted event exactly once.
module flag_pacer
  import flag_cdc_pkg::*;
#(
  parameter int GAP   = DEF_GAP,
  parameter int CNT_W = 4
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             ev,
  input  logic             clr_ovf,
  output logic             A,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 2);

  if (GAP < 2) begin : g_bad_gap
    $error("flag_pacer: GAP must be 2 or more");
  end

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          a_q, a_d;
  logic          ovf_q, ovf_d;
  logic          issue, drop, full;

  // Issue decisions see only the registered count; a same-cycle ev is queued, not bypassed.
  sat_updown_cnt #(.W(CNT_W)) u_pending (
    .clk   (clkA),
    .rst   (rst),
    .inc   (ev),
    .dec   (issue),
    .count (pending),
    .full  (full),
    .drop  (drop)
  );

  always_ff @(posedge clkA) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      a_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  // SPACE holds GAP-2 countdown cycles; together with the PULSE and SPACE-exit cycles, this gives a spacing of exactly GAP.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          issue   = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
        gap_d   = GAP_LOAD;
        state_d = SPACE;
      end
      SPACE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (pending != '0) begin
          issue   = 1'b1;
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d = issue;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  assign A        = a_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || (pending != '0) || full;

endmodule

// File: tb/tb_flag_pacer.sv
// Bench for flag_pacer: directed scenarios plus random traffic, compared every cycle against a rule-level model.
// Two instances share the stimulus: CNT_W=4 (deep queue) and CNT_W=2 (saturates at 3).
module tb_flag_pacer;

  localparam int GAP = 6;

  logic clkA = 1'b0;
  logic rst, ev, clr_ovf;

  logic       a_b, busy_b, ovf_b;
  logic [3:0] pend_b;
  logic       a_s, busy_s, ovf_s;
  logic [1:0] pend_s;

  always #5 clkA = ~clkA;

  flag_pacer #(.GAP(GAP), .CNT_W(4)) dut_big (
    .clkA(clkA), .rst(rst), .ev(ev), .clr_ovf(clr_ovf),
    .A(a_b), .pending(pend_b), .busy(busy_b), .overflow(ovf_b)
  );

  flag_pacer #(.GAP(GAP), .CNT_W(2)) dut_small (
    .clkA(clkA), .rst(rst), .ev(ev), .clr_ovf(clr_ovf),
    .A(a_s), .pending(pend_s), .busy(busy_s), .overflow(ovf_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count of queued events, edge of the last A rise, sticky overflow.
  int m_max [2] = '{15, 3};
  int m_pend[2];
  int m_last[2];
  int m_ovf [2];
  int m_a   [2];
  int t = 0;
  int pulses[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic ev_v, input logic clr_v, input logic rst_v);
    for (int k = 0; k < 2; k++) begin
      if (rst_v) begin
        m_pend[k] = 0;
        m_ovf[k]  = 0;
        m_last[k] = -1000;
        m_a[k]    = 0;
      end else begin
        int  iss, drp;
        iss = (m_pend[k] > 0 && (t - m_last[k]) >= GAP) ? 1 : 0;
        drp = (ev_v && iss == 0 && m_pend[k] == m_max[k]) ? 1 : 0;
        m_pend[k] = m_pend[k] + ((ev_v && drp == 0) ? 1 : 0) - iss;
        if (drp == 1)   m_ovf[k] = 1;
        else if (clr_v) m_ovf[k] = 0;
        m_a[k] = iss;
        if (iss == 1) m_last[k] = t;
      end
    end
  endtask

  function automatic int m_busy(input int k);
    return (m_pend[k] != 0 || (t - m_last[k]) < GAP) ? 1 : 0;
  endfunction

  task automatic step(input logic ev_v, input logic clr_v, input logic rst_v);
    ev      = ev_v;
    clr_ovf = clr_v;
    rst     = rst_v;
    @(posedge clkA);
    t++;
    model_edge(ev_v, clr_v, rst_v);
    @(negedge clkA);
    check($sformatf("big_A@%0d", t),        32'(a_b),    32'(m_a[0]));
    check($sformatf("big_pending@%0d", t),  32'(pend_b), 32'(m_pend[0]));
    check($sformatf("big_busy@%0d", t),     32'(busy_b), 32'(m_busy(0)));
    check($sformatf("big_ovf@%0d", t),      32'(ovf_b),  32'(m_ovf[0]));
    check($sformatf("small_A@%0d", t),      32'(a_s),    32'(m_a[1]));
    check($sformatf("small_pending@%0d", t),32'(pend_s), 32'(m_pend[1]));
    check($sformatf("small_busy@%0d", t),   32'(busy_s), 32'(m_busy(1)));
    check($sformatf("small_ovf@%0d", t),    32'(ovf_s),  32'(m_ovf[1]));
    if (a_b === 1'b1) pulses[0]++;
    if (a_s === 1'b1) pulses[1]++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ev = 1'b0; clr_ovf = 1'b0; rst = 1'b1;
    m_pend = '{0, 0}; m_ovf = '{0, 0}; m_a = '{0, 0}; m_last = '{-1000, -1000};
    pulses = '{0, 0};
    @(negedge clkA);

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("reset_A", 32'(a_b), 0);
    check("reset_busy", 32'(busy_b), 0);
    idle(2);

    // Single event: ev at edge 0, A in the cycle after edge 1, busy low from edge 7
    step(1'b1, 1'b0, 1'b0);
    check("single_pending_e0", 32'(pend_b), 1);
    step(1'b0, 1'b0, 1'b0);
    check("single_A_e1", 32'(a_b), 1);
    check("single_pending_e1", 32'(pend_b), 0);
    idle(5);
    check("single_busy_e6", 32'(busy_b), 1);
    step(1'b0, 1'b0, 1'b0);
    check("single_busy_e7", 32'(busy_b), 0);
    check("single_ovf", 32'(ovf_b), 0);
    idle(3);

    // Burst of three: three pulses at edges 1, 7 and 13
    pulses = '{0, 0};
    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(20);
    check("burst_pulses", 32'(pulses[0]), 3);

    // Saturation: five events; the small instance drops one
    pulses = '{0, 0};
    repeat (5) step(1'b1, 1'b0, 1'b0);
    idle(30);
    check("sat_small_pulses", 32'(pulses[1]), 4);
    check("sat_big_pulses", 32'(pulses[0]), 5);
    check("sat_small_ovf_sticky", 32'(ovf_s), 1);
    check("sat_big_ovf", 32'(ovf_b), 0);

    // clr_ovf coinciding with a fresh drop: the set wins
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("clr_with_drop_ovf", 32'(ovf_s), 1);
    idle(30);
    step(1'b0, 1'b1, 1'b0);
    check("clr_alone_ovf", 32'(ovf_s), 0);
    idle(2);

    // Reset while in SPACE with events queued
    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    check("rst_mid_A", 32'(a_b), 0);
    check("rst_mid_pending", 32'(pend_b), 0);
    check("rst_mid_busy", 32'(busy_b), 0);
    check("rst_mid_ovf", 32'(ovf_b), 0);
    pulses = '{0, 0};
    idle(20);
    check("rst_mid_no_stale", 32'(pulses[0]), 0);

    // Simultaneous ev and issue: pending holds at 1, second pulse follows GAP later
    pulses = '{0, 0};
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("simul_pending", 32'(pend_b), 1);
    check("simul_A", 32'(a_b), 1);
    idle(15);
    check("simul_pulses", 32'(pulses[0]), 2);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_pacer.md
Name: flag_pacer

Overview:
Upstream feeder for flag_cdc, running in the clkA domain. flag_cdc can lose an event if two A pulses arrive closer together than the synchroniser can resolve. This block accepts event strobes at any rate, queues them in a saturating pending counter, and drives A with single-cycle pulses spaced at least GAP clkA cycles apart. Every accepted event is therefore seen once on B.

Parameters:
GAP, 6, minimum clkA cycles between the rising edges of consecutive A pulses; legal range is 2 or more, and GAP<2 is an elaboration error.
CNT_W, 4, width of the pending-event counter; holds at most 2^CNT_W-1 events.

Ports:
clkA  input  1  sole clock; the flag_cdc source-domain clock.
rst  input  1  synchronous, active-high reset.
ev  input  1  event strobe; each high cycle is one event.
clr_ovf  input  1  clears the sticky overflow flag.
A  output  1  registered single-cycle pulse; connects to flag_cdc.A.
pending  output  CNT_W  number of accepted events not yet issued on A.
busy  output  1  high when state is not IDLE or pending is not 0.
overflow  output  1  sticky flag; set when an event is dropped.

Behaviour:
- Interface: one clock (clkA); reset (rst) is synchronous and active-high.
- Reset values: A=0, pending=0, overflow=0, busy=0, state=IDLE, gap counter=0. Reset applied mid-operation discards all queued events, and A is 0 from the next edge onward.
- Pending counter:
  - ev high and no issue: pending+1.
  - Issue and ev low: pending-1.
  - Both in the same cycle: pending unchanged.
- Saturation: ev while pending=2^CNT_W-1 and no issue in the same cycle drops the event and sets overflow=1. ev at max together with an issue is accepted, and overflow is not set.
- overflow stays high until clr_ovf. If clr_ovf and a new drop occur in the same cycle, set wins (overflow=1).
- FSM states are IDLE, PULSE and SPACE.
  - IDLE: if pending!=0, issue, meaning A=1 on the next edge, pending is decremented, and the next state is PULSE.
  - PULSE: A=0 on the next edge, gap counter loads GAP-2, next state SPACE.
  - SPACE: count down. When the count reaches 0, issue immediately if pending!=0 (giving back-to-back spacing of exactly GAP); otherwise go to IDLE.
- Issue decisions use the registered pending value only. An ev arriving in the same cycle does not bypass the counter.
- Latency:
  - ev at edge n with an empty, IDLE block gives A=1 for exactly the cycle following edge n+1.
  - Rising edges of A under backlog are exactly GAP cycles apart.
- A is never high for two consecutive cycles.
- busy is combinational from registered state.
- Gap counter width is $clog2(GAP). Arithmetic is unsigned and never wraps: saturating up, and no decrement at 0.

Decomposition:
- Package flag_cdc_pkg holds:
  - the state typedef enum {IDLE, PULSE, SPACE};
  - localparam DEF_GAP=6;
  - a helper function min_gap(periodA, periodB) for integration checks.
- One sub-module: sat_updown_cnt (parameter W; ports inc, dec, count, full, drop), which implements the pending counter and drop detection.

Test Plan:
- Single event: rst released, ev high for 1 cycle at edge 0. Required: A high only in the cycle after edge 1; pending returns 1→0; busy falls after the SPACE state ends (edge 7 with GAP=6); overflow=0.
- Burst, GAP=6: ev high for 3 consecutive cycles starting at edge 0. Required: A rising edges at edges 1, 7 and 13; pending sequence 1,1,2,2…,1…,0; exactly 3 pulses.
- Saturation, CNT_W=2, GAP=6: ev high for 5 cycles. Required: exactly 4 A pulses; 1 event dropped at edge 4; overflow=1 stays set after activity ends. Pulse clr_ovf together with a fresh drop: overflow stays 1. A clr_ovf alone afterwards clears it to 0.
- Reset mid-operation: 3 events queued, rst asserted while in SPACE. Required: the next edge gives A=0, pending=0, overflow=0, busy=0. After rst falls, no stale pulses appear.
- Simultaneous ev and issue: backlog of 1, ev asserted on the issue edge. Required: pending stays 1, and a second A pulse follows GAP cycles later.
- End-to-end with flag_cdc, 2 cases:
  - clkA period 5 / clkB period 10: 3 back-to-back ev strobes give exactly 3 B pulses.
  - clkA period 10 / clkB period 5: same result.
